// File: rtl/matrix_to_sevenseg.sv
// Rebuilds strobed 4x8 LED-matrix scans into active-low seven-segment codes and flags malformed frames.
// Optional `FRAME_AGREE_EN: a clean code is committed only when it matches the previous clean decode.
module matrix_to_sevenseg #(
    parameter int SETTLE    = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] io_out,
    input  logic [3:0] io_col,
    output logic [7:0] seg_out,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale
);
    localparam int SW = $clog2(SETTLE + 1);
    // Rows carrying segment pixels in column 0, columns 1/2 and column 3.
    localparam logic [7:0] MASK0  = 8'h36;
    localparam logic [7:0] MASK12 = 8'h49;
    localparam logic [7:0] MASK3  = 8'hB6;

    typedef enum logic [1:0] {HUNT, CAP, DECODE} state_t;

    logic [7:0]           out_m, out_q, rows_s;
    logic [3:0]           col_m, col_q, col_s, col_prev;
    logic                 col_legal, col_changed, settled, sample, bad_hold;
    logic [1:0]           col_idx, exp_col;
    logic [SW-1:0]        settle_cnt;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic [7:0]           frame [4];
    logic [7:0]           seg_dec;
    logic                 blank_lit, cap_err, dec_err, dec_ok, commit;
    state_t               state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_m <= '1;
            out_q <= '1;
            col_m <= '1;
            col_q <= '1;
        end else begin
            out_m <= io_out;
            out_q <= out_m;
            col_m <= io_col;
            col_q <= col_m;
        end
    end

    assign rows_s    = ~out_q;
    assign col_s     = ~col_q;
    assign col_legal = (col_s != 4'd0) && ((col_s & (col_s - 4'd1)) == 4'd0);

    always_comb begin
        col_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (col_s[i]) col_idx = 2'(i);
    end

    // Sample fires on the cycle the counter steps onto SETTLE-1, once per column phase.
    assign col_changed = (col_s != col_prev);
    assign settled     = !col_changed && (settle_cnt == SW'(SETTLE - 2));
    assign sample      = settled && col_legal;
    assign bad_hold    = settled && !col_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_prev   <= 4'd0;
            settle_cnt <= '0;
            idle_cnt   <= '0;
        end else begin
            col_prev <= col_s;
            if (col_changed)
                settle_cnt <= '0;
            else if (settle_cnt != SW'(SETTLE))
                settle_cnt <= settle_cnt + 1'b1;
            if (col_changed && col_legal)
                idle_cnt <= '0;
            else if (!(&idle_cnt))
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign stale = &idle_cnt;

    // Segment order {dp,g,f,e,d,c,b,a}; a segment is on when either pixel of its pair is lit.
    assign seg_dec = ~{frame[3][7],
                       frame[1][3] | frame[2][3],
                       frame[0][1] | frame[0][2],
                       frame[0][4] | frame[0][5],
                       frame[1][6] | frame[2][6],
                       frame[3][4] | frame[3][5],
                       frame[3][1] | frame[3][2],
                       frame[1][0] | frame[2][0]};
    assign blank_lit = (|(frame[0] & ~MASK0))  || (|(frame[1] & ~MASK12)) ||
                       (|(frame[2] & ~MASK12)) || (|(frame[3] & ~MASK3));

    assign cap_err = (state == CAP) && ((sample && (col_idx != exp_col)) || bad_hold);
    assign dec_err = (state == DECODE) && blank_lit;
    assign dec_ok  = (state == DECODE) && !blank_lit;

`ifdef FRAME_AGREE_EN
    logic [7:0] hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold <= 8'hFF;
        else if (cap_err || dec_err)
            hold <= 8'hFF;
        else if (dec_ok)
            hold <= seg_dec;
    end

    assign commit = dec_ok && (seg_dec == hold);
`else
    assign commit = dec_ok;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            exp_col     <= 2'd0;
            for (int i = 0; i < 4; i++) frame[i] <= 8'd0;
            seg_out     <= 8'hFF;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= commit;
            frame_err   <= cap_err || dec_err;
            if (commit) seg_out <= seg_dec;
            case (state)
                HUNT: begin
                    if (sample && (col_idx == 2'd0)) begin
                        frame[0] <= rows_s;
                        exp_col  <= 2'd1;
                        state    <= CAP;
                    end
                end
                CAP: begin
                    if (sample) begin
                        if (col_idx == exp_col) begin
                            frame[col_idx] <= rows_s;
                            if (exp_col == 2'd3) state <= DECODE;
                            else exp_col <= exp_col + 2'd1;
                        end else if (col_idx == 2'd0) begin
                            frame[0] <= rows_s;
                            exp_col  <= 2'd1;
                        end else begin
                            state <= HUNT;
                        end
                    end else if (bad_hold) begin
                        state <= HUNT;
                    end
                end
                DECODE: begin
                    exp_col <= 2'd0;
                    state   <= CAP;
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_to_sevenseg.sv
// Randomised scan-level bench for matrix_to_sevenseg: a frame-level model predicts every
// frame_valid / frame_err pulse and the committed seg_out.
module tb_matrix_to_sevenseg;
    localparam int SETTLE = 4;
    localparam int TW     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] io_out;
    logic [3:0] io_col;
    logic [7:0] seg_out;
    logic       frame_valid, frame_err, stale;

    int n_cmp = 0;
    int n_bad = 0;

    // Pixel table: segment index, row and column of every segment pixel.
    localparam int PIX_SEG [15] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7};
    localparam int PIX_ROW [15] = '{0, 0, 1, 2, 4, 5, 6, 6, 4, 5, 1, 2, 3, 3, 7};
    localparam int PIX_COL [15] = '{1, 2, 3, 3, 3, 3, 1, 2, 0, 0, 0, 0, 1, 2, 3};

    logic [9:0] exp_q [$];   // {err, valid, seg_out}
    logic [7:0] mf [4];
    bit         m_cap;
    int         m_exp;
    logic [7:0] m_seg, m_hold;
    logic [3:0] last_col;

    matrix_to_sevenseg #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
        .clk(clk), .reset(reset), .io_out(io_out), .io_col(io_col),
        .seg_out(seg_out), .frame_valid(frame_valid), .frame_err(frame_err), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int pixel_seg(input int c, input int r);
        for (int p = 0; p < 15; p++)
            if (PIX_COL[p] == c && PIX_ROW[p] == r) return PIX_SEG[p];
        return -1;
    endfunction

    function automatic logic [7:0] lit_rows(input logic [7:0] code, input int c);
        logic [7:0] v = 8'd0;
        for (int p = 0; p < 15; p++)
            if (PIX_COL[p] == c && !code[PIX_SEG[p]]) v[PIX_ROW[p]] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_cap = 0; m_exp = 0; m_seg = 8'hFF; m_hold = 8'hFF; last_col = 4'd0;
    endtask

    task automatic model_err();
        exp_q.push_back({2'b10, m_seg});
        m_hold = 8'hFF;
    endtask

    task automatic model_decode();
        logic [7:0] code = 8'hFF;
        bit blank = 0;
        bit commit;
        int s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 8; r++)
                if (mf[c][r]) begin
                    s = pixel_seg(c, r);
                    if (s < 0) blank = 1;
                    else code[s] = 1'b0;
                end
        if (blank) begin
            model_err();
        end else begin
`ifdef FRAME_AGREE_EN
            commit = (code == m_hold);
            m_hold = code;
`else
            commit = 1;
`endif
            if (commit) begin
                m_seg = code;
                exp_q.push_back({2'b01, code});
            end
        end
    endtask

    task automatic model_phase(input logic [3:0] col, input logic [7:0] lit);
        int idx = 0;
        if ($countones(col) != 1) begin
            if (m_cap) model_err();
            m_cap = 0;
            return;
        end
        for (int i = 0; i < 4; i++) if (col[i]) idx = i;
        if (!m_cap) begin
            if (idx == 0) begin mf[0] = lit; m_cap = 1; m_exp = 1; end
            return;
        end
        if (idx == m_exp) begin
            mf[idx] = lit;
            if (idx == 3) begin model_decode(); m_exp = 0; end
            else m_exp++;
        end else begin
            model_err();
            if (idx == 0) begin mf[0] = lit; m_exp = 1; end
            else m_cap = 0;
        end
    endtask

    task automatic drive_phase(input logic [3:0] col, input logic [7:0] lit, input int cycles);
        if (col != last_col) model_phase(col, lit);
        last_col = col;
        io_col = ~col;
        io_out = ~lit;
        repeat (cycles) @(posedge clk);
        #1;
        check("seg_out", seg_out, m_seg);
    endtask

    task automatic scan(input logic [7:0] code, input int blank_c, input int blank_r);
        logic [7:0] lit;
        for (int c = 0; c < 4; c++) begin
            lit = lit_rows(code, c);
            if (c == blank_c) lit[blank_r] = 1'b1;
            drive_phase(4'(1 << c), lit, $urandom_range(10, 20));
        end
    endtask

    task automatic do_reset(input logic [3:0] col, input logic [7:0] lit);
        reset = 1'b1;
        io_col = ~col;
        io_out = ~lit;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_out", seg_out, 8'hFF);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_stale", stale, 0);
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) check("event_unexpected", {frame_err, frame_valid, seg_out}, 32'h0);
            else check("event", {frame_err, frame_valid, seg_out}, exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] code, last_code, bad;
        int kind, c, r;
        model_reset();
        // Reset released in the middle of col2: the partial scan is ignored.
        do_reset(4'b0100, lit_rows(8'hF9, 2));
        drive_phase(4'b0100, lit_rows(8'hF9, 2), 12);
        drive_phase(4'b1000, lit_rows(8'hF9, 3), 12);
        scan(8'hF9, -1, 0);
        repeat (3) scan(8'h80, -1, 0);
        // Column order 0,1,3.
        drive_phase(4'b0001, lit_rows(8'h80, 0), 12);
        drive_phase(4'b0010, lit_rows(8'h80, 1), 12);
        drive_phase(4'b1000, lit_rows(8'h80, 3), 12);
        // "0" with blank pixel r0c0 lit.
        scan(8'hC0, 0, 0);
        // No legal activity long enough to saturate the idle counter.
        drive_phase(4'b0001, lit_rows(8'hC0, 0), 12);
        drive_phase(4'b0000, 8'h00, 100);
        check("stale_low", stale, 0);
        drive_phase(4'b0000, 8'h00, 200);
        check("stale_high", stale, 1);
        drive_phase(4'b0001, lit_rows(8'hC0, 0), 6);
        check("stale_clear", stale, 0);
        drive_phase(4'b0001, lit_rows(8'hC0, 0), 8);
        drive_phase(4'b0010, lit_rows(8'hC0, 1), 12);
        drive_phase(4'b0100, lit_rows(8'hC0, 2), 12);
        drive_phase(4'b1000, lit_rows(8'hC0, 3), 12);
        // Alternating codes, then a repeated code.
        scan(8'hC0, -1, 0);
        scan(8'hF9, -1, 0);
        scan(8'hC0, -1, 0);
        scan(8'hF9, -1, 0);
        scan(8'hC0, -1, 0);
        scan(8'hC0, -1, 0);
        // Reset in the middle of a frame.
        drive_phase(4'b0001, lit_rows(8'hA4, 0), 12);
        drive_phase(4'b0010, lit_rows(8'hA4, 1), 12);
        do_reset(4'b0010, lit_rows(8'hA4, 1));
        drive_phase(4'b0100, lit_rows(8'hA4, 2), 12);
        drive_phase(4'b1000, lit_rows(8'hA4, 3), 12);
        scan(8'hA4, -1, 0);
        last_code = 8'hA4;
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 9);
            code = ($urandom_range(0, 2) == 0) ? last_code : 8'($urandom);
            if (kind <= 5) begin
                scan(code, -1, 0);
            end else if (kind == 6) begin
                do begin
                    c = $urandom_range(0, 3);
                    r = $urandom_range(0, 7);
                end while (pixel_seg(c, r) >= 0);
                scan(code, c, r);
            end else if (kind == 7) begin
                repeat ($urandom_range(2, 5)) begin
                    c = $urandom_range(0, 3);
                    drive_phase(4'(1 << c), lit_rows(code, c), $urandom_range(10, 20));
                end
            end else if (kind == 8) begin
                drive_phase(4'b0001, lit_rows(code, 0), $urandom_range(10, 20));
                do bad = 8'($urandom); while ($countones(bad[3:0]) == 1);
                drive_phase(bad[3:0], 8'($urandom), $urandom_range(10, 20));
            end else begin
                for (int cc = 0; cc < 4; cc++)
                    drive_phase(4'(1 << cc), 8'($urandom), $urandom_range(10, 20));
            end
            last_code = code;
        end
        repeat (20) @(posedge clk);
        #1;
        check("events_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
